// File: rtl/traffic_pkg.sv
// Shared encodings and classification helpers for the traffic density encoder.
package traffic_pkg;

    localparam int unsigned QUEUE_W = 6;
    localparam logic [QUEUE_W-1:0] QUEUE_MAX = '1;

    localparam logic [1:0] LOW  = 2'b00;
    localparam logic [1:0] MOD  = 2'b01;
    localparam logic [1:0] HIGH = 2'b10;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    function automatic logic [1:0] classify(input logic [QUEUE_W-1:0] q, input int mod_th,
                                            input int high_th);
        if (int'(q) >= high_th) return HIGH;
        if (int'(q) >= mod_th) return MOD;
        return LOW;
    endfunction

    // Upgrades are immediate; downgrades need the queue to fall HYST below the threshold.
    // Encodings are ordered, so a numeric compare distinguishes upgrade from downgrade.
    function automatic logic [1:0] classify_hyst(input logic [QUEUE_W-1:0] q,
                                                 input logic [1:0] cur, input int mod_th,
                                                 input int high_th, input int hyst);
        logic [1:0] raw;
        logic [1:0] lvl;
        raw = classify(q, mod_th, high_th);
        if (raw >= cur) return raw;
        lvl = cur;
        if (lvl == HIGH) begin
            if (int'(q) < high_th - hyst) lvl = MOD;
            else return HIGH;
        end
        if (lvl == MOD && int'(q) < mod_th - hyst) lvl = LOW;
        return lvl;
    endfunction

endpackage

// File: rtl/approach_queue.sv
// One approach: arrival edge detect, green-light departure timer and saturating queue count.
module approach_queue
    import traffic_pkg::*;
#(
    parameter int unsigned DEPART_CYCLES = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               car_i,
    input  logic [1:0]         light_i,
    output logic [QUEUE_W-1:0] queue_o
);

    localparam int unsigned TMR_W = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;

    logic               car_prev_q;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [QUEUE_W-1:0] queue_q, queue_d;
    logic               arrival;
    logic               depart;
    logic               green;

    assign arrival = car_i & ~car_prev_q;
    assign green   = (light_i == GREEN);

    always_comb begin
        timer_d = '0;
        depart  = 1'b0;
        if (green) begin
            if (timer_q == TMR_W'(DEPART_CYCLES - 1)) begin
                depart = 1'b1;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end
    end

    always_comb begin
        queue_d = queue_q;
        unique case ({arrival, depart})
            2'b10:   if (queue_q != QUEUE_MAX) queue_d = queue_q + QUEUE_W'(1);
            2'b01:   if (queue_q != '0) queue_d = queue_q - QUEUE_W'(1);
            default: queue_d = queue_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            car_prev_q <= 1'b0;
            timer_q    <= '0;
            queue_q    <= '0;
        end else begin
            car_prev_q <= car_i;
            timer_q    <= timer_d;
            queue_q    <= queue_d;
        end
    end

    assign queue_o = queue_q;

endmodule

// File: rtl/traffic_density_encoder.sv
// Per-approach congestion levels refreshed once per window.
// Define TRAFFIC_HYST_EN to add downgrade hysteresis of HYST vehicles.
module traffic_density_encoder
    import traffic_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 32,
    parameter int unsigned DEPART_CYCLES = 4,
    parameter int unsigned MOD_TH        = 8,
    parameter int unsigned HIGH_TH       = 20,
    parameter int unsigned HYST          = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       car_NS,
    input  logic       car_EW,
    input  logic [1:0] NS_light,
    input  logic [1:0] EW_light,
    output logic [1:0] traffic_NS,
    output logic [1:0] traffic_EW,
    output logic       level_valid
);

    localparam int unsigned WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

    logic [WIN_W-1:0]   win_q;
    logic               win_end;
    logic [QUEUE_W-1:0] queue_ns;
    logic [QUEUE_W-1:0] queue_ew;
    logic [1:0]         level_ns_d;
    logic [1:0]         level_ew_d;

    approach_queue #(
        .DEPART_CYCLES(DEPART_CYCLES)
    ) u_ns (
        .clk_i  (clk),
        .rst_i  (rst),
        .car_i  (car_NS),
        .light_i(NS_light),
        .queue_o(queue_ns)
    );

    approach_queue #(
        .DEPART_CYCLES(DEPART_CYCLES)
    ) u_ew (
        .clk_i  (clk),
        .rst_i  (rst),
        .car_i  (car_EW),
        .light_i(EW_light),
        .queue_o(queue_ew)
    );

    assign win_end = (win_q == WIN_W'(WINDOW_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q <= '0;
        end else if (win_end) begin
            win_q <= '0;
        end else begin
            win_q <= win_q + WIN_W'(1);
        end
    end

    always_comb begin
        level_ns_d = traffic_NS;
        level_ew_d = traffic_EW;
        if (win_end) begin
`ifdef TRAFFIC_HYST_EN
            level_ns_d = classify_hyst(queue_ns, traffic_NS, int'(MOD_TH), int'(HIGH_TH),
                                       int'(HYST));
            level_ew_d = classify_hyst(queue_ew, traffic_EW, int'(MOD_TH), int'(HIGH_TH),
                                       int'(HYST));
`else
            level_ns_d = classify(queue_ns, int'(MOD_TH), int'(HIGH_TH));
            level_ew_d = classify(queue_ew, int'(MOD_TH), int'(HIGH_TH));
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            traffic_NS  <= LOW;
            traffic_EW  <= LOW;
            level_valid <= 1'b0;
        end else begin
            traffic_NS  <= level_ns_d;
            traffic_EW  <= level_ew_d;
            level_valid <= win_end;
        end
    end

endmodule

// File: doc/traffic_density_encoder.md
TRAFFIC_DENSITY_ENCODER -- requirements
Module: traffic_density_encoder

Interface
REQ-001 Parameter WINDOW_CYCLES, default 32: clock cycles between output level updates.
REQ-002 Parameter DEPART_CYCLES, default 4: green-light cycles per vehicle departure.
REQ-003 Parameter MOD_TH, default 8: queue length at or above which the level is moderate.
REQ-004 Parameter HIGH_TH, default 20: queue length at or above which the level is high.
REQ-005 Parameter HYST, default 2: downgrade margin, used only when TRAFFIC_HYST_EN is defined.
REQ-006 Port clk, input, 1: single system clock; all state SHALL update on its rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-high reset.
REQ-008 Port car_NS / car_EW, input, 1 each: synchronous vehicle sensor levels; each rising edge is one arrival.
REQ-009 Port NS_light / EW_light, input, 2 each: controller light state; 00 red, 01 yellow, 10 green, 11 treated as red.
REQ-010 Port traffic_NS / traffic_EW, output, 2 each: registered congestion level; 00 low, 01 moderate, 10 high; 11 SHALL never be driven.
REQ-011 Port level_valid, output, 1: one-cycle pulse in the cycle the levels are updated.

Function
REQ-012 Per approach, a 6-bit queue count SHALL be kept, saturating at 63 and flooring at 0.
REQ-013 Arrival detection SHALL register the previous sensor value and flag car & ~car_prev; a sensor held high SHALL count once.
REQ-014 Per approach, a departure timer SHALL run only while that light is green; it SHALL clear whenever the light is not green.
REQ-015 A departure SHALL occur when the timer reaches DEPART_CYCLES-1 while green; the timer SHALL then wrap to 0.
REQ-016 A departure with queue 0 SHALL leave the queue at 0.
REQ-017 A simultaneous arrival and departure SHALL leave the queue unchanged.
REQ-018 A free-running window counter SHALL count 0..WINDOW_CYCLES-1 and wrap.
REQ-019 When the window counter equals WINDOW_CYCLES-1, both levels SHALL be reclassified from the queue values at that edge, and level_valid SHALL pulse in the same cycle.
REQ-020 Classification: queue >= HIGH_TH gives 10; MOD_TH <= queue < HIGH_TH gives 01; otherwise 00.
REQ-021 Between updates, traffic_NS and traffic_EW SHALL hold stable.

Reset
REQ-022 rst high SHALL immediately clear queues, timers, sensor history, the window counter, traffic_NS/EW (00) and level_valid (0).
REQ-023 After rst deasserts, the first level update SHALL occur WINDOW_CYCLES cycles later.
REQ-024 A reset mid-window SHALL discard all partial counts; no stale level_valid pulse is produced.

Configuration
REQ-025 With TRAFFIC_HYST_EN defined, upgrades SHALL follow REQ-020 unchanged.
REQ-026 With TRAFFIC_HYST_EN defined, downgrades SHALL be restricted: 10 drops only when queue < HIGH_TH-HYST, and 01 drops to 00 only when queue < MOD_TH-HYST.
REQ-027 With TRAFFIC_HYST_EN defined, a downgrade from 10 SHALL reclassify by the 01 rule in the same update.
REQ-028 Without TRAFFIC_HYST_EN, classification SHALL be purely REQ-020 and the HYST parameter SHALL be unused.

Structure
REQ-029 Package traffic_pkg SHALL hold the level encodings (LOW/MOD/HIGH), light encodings (RED/YELLOW/GREEN) and the queue width constant (6).
REQ-030 Sub-module approach_queue SHALL contain edge detect, departure timer and saturating queue, instantiated once per approach.
REQ-031 The top level SHALL contain the shared window counter, classification and output registers.

Verification
REQ-032 Both lights red, 10 car_NS pulses in the first window -> at the first boundary traffic_NS=01, traffic_EW=00, level_valid=1 for one cycle.
REQ-033 Both lights red, 25 car_EW pulses -> traffic_EW=10 at the next boundary; car_EW held high for 100 cycles adds exactly 1.
REQ-034 NS queue 12, NS_light=10 for 16 cycles with no arrivals -> queue 8 and traffic_NS=01 at the boundary; arrival coincident with departure -> queue unchanged.
REQ-035 70 arrivals on NS -> queue 63 (saturated); green held 300 cycles with DEPART_CYCLES=4 -> queue 0, traffic_NS=00, no underflow.
REQ-036 Queue 8 (level 01), then departures to queue 7 -> 01 retained with TRAFFIC_HYST_EN, 00 without; at queue 5 -> 00 in both builds.
REQ-037 rst pulsed mid-window with queues at 15/30 -> outputs 00 during rst, queues 0, next level_valid exactly WINDOW_CYCLES cycles after release.
